// File: rtl/timer_sched.sv
// Tick/reload scheduler for the four hardware timers: start FSM, prescaler, cascade chain, IRQ.
// Optional TIMER_SCHED_SOUND_REQ_EN adds snd_tick, registered copies of ovf[1:0].
module timer_sched #(
  parameter int unsigned START_DELAY = 1,
  parameter int unsigned PSC_W       = 10
) (
  input  logic        clock_16,
  input  logic        reset,
  input  logic [15:0] tm0_ctrl,
  input  logic [15:0] tm1_ctrl,
  input  logic [15:0] tm2_ctrl,
  input  logic [15:0] tm3_ctrl,
  input  logic [15:0] tm0_cnt,
  input  logic [15:0] tm1_cnt,
  input  logic [15:0] tm2_cnt,
  input  logic [15:0] tm3_cnt,
  output logic [3:0]  tick,
  output logic [3:0]  reload,
  output logic [3:0]  ovf,
  output logic [3:0]  irq
`ifdef TIMER_SCHED_SOUND_REQ_EN
  ,
  output logic [1:0]  snd_tick
`endif
);

  typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;

  localparam logic [1:0] DlyLast = 2'(START_DELAY - 1);

  state_e           state_q [4];
  state_e           state_d [4];
  logic [PSC_W-1:0] psc_q   [4];
  logic [PSC_W-1:0] psc_d   [4];
  logic [1:0]       dly_q   [4];
  logic [1:0]       dly_d   [4];
  logic [15:0]      ctrl    [4];
  logic [15:0]      cnt     [4];
  logic [3:0]       start_prev_q, start_rld_q, start_rld_d, irq_q, irq_d;
  logic [3:0]       start_bit, irq_en, cascade, tick_c, ovf_c;
  logic             unused_ctrl;

  assign ctrl = '{tm0_ctrl, tm1_ctrl, tm2_ctrl, tm3_ctrl};
  assign cnt  = '{tm0_cnt, tm1_cnt, tm2_cnt, tm3_cnt};

  assign start_bit = {tm3_ctrl[7], tm2_ctrl[7], tm1_ctrl[7], tm0_ctrl[7]};
  assign irq_en    = {tm3_ctrl[6], tm2_ctrl[6], tm1_ctrl[6], tm0_ctrl[6]};
  // Timer 0 has no predecessor, so its count-up bit is ignored.
  assign cascade   = {tm3_ctrl[2], tm2_ctrl[2], tm1_ctrl[2], 1'b0};

  assign unused_ctrl = ^{tm0_ctrl[15:8], tm0_ctrl[5:2], tm1_ctrl[15:8], tm1_ctrl[5:3],
                         tm2_ctrl[15:8], tm2_ctrl[5:3], tm3_ctrl[15:8], tm3_ctrl[5:3]};

  function automatic logic [PSC_W-1:0] psc_lim(input logic [1:0] sel);
    case (sel)
      2'd0:    return '0;
      2'd1:    return PSC_W'(63);
      2'd2:    return PSC_W'(255);
      default: return PSC_W'(1023);
    endcase
  endfunction

  always_ff @(posedge clock_16) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        psc_q[i]   <= '0;
        dly_q[i]   <= '0;
      end
      start_prev_q <= '0;
      start_rld_q  <= '0;
      irq_q        <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        psc_q[i]   <= psc_d[i];
        dly_q[i]   <= dly_d[i];
      end
      start_prev_q <= start_bit;
      start_rld_q  <= start_rld_d;
      irq_q        <= irq_d;
    end
  end

  always_comb begin
    start_rld_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      psc_d[i]   = psc_q[i];
      dly_d[i]   = dly_q[i];
      if (!start_bit[i]) begin
        state_d[i] = StIdle;
        psc_d[i]   = '0;
        dly_d[i]   = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (!start_prev_q[i]) begin
              state_d[i]     = StStart;
              psc_d[i]       = '0;
              dly_d[i]       = '0;
              start_rld_d[i] = 1'b1;
            end
          end
          StStart: begin
            if (dly_q[i] == DlyLast) state_d[i] = StRun;
            else                     dly_d[i]   = dly_q[i] + 2'd1;
          end
          StRun: begin
            if (cascade[i] || tick_c[i]) psc_d[i] = '0;
            else                         psc_d[i] = psc_q[i] + PSC_W'(1);
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  // Cascade carry ripples 0->1->2->3 within one cycle.
  always_comb begin : out_comb
    logic carry;
    tick_c = '0;
    ovf_c  = '0;
    carry  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (state_q[i] == StRun) begin
        tick_c[i] = cascade[i] ? carry : (psc_q[i] >= psc_lim(ctrl[i][1:0]));
      end
      ovf_c[i] = tick_c[i] & (cnt[i] == 16'hFFFF);
      carry    = ovf_c[i];
    end
  end

  assign irq_d  = ovf_c & irq_en;
  assign tick   = tick_c;
  assign ovf    = ovf_c;
  assign reload = start_rld_q | ovf_c;
  assign irq    = irq_q;

`ifdef TIMER_SCHED_SOUND_REQ_EN
  logic [1:0] snd_q;

  always_ff @(posedge clock_16) begin
    if (reset) snd_q <= '0;
    else       snd_q <= ovf_c[1:0];
  end

  assign snd_tick = snd_q;
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: per-cycle expectations queued with stimulus, checked at negedge.
module tb_timer_sched;

  localparam int SelTick = 0;
  localparam int SelRld  = 1;
  localparam int SelOvf  = 2;
  localparam int SelIrq  = 3;

  typedef logic [8*16-1:0] tag_t;
  typedef struct packed {
    int         cyc;
    tag_t       tag;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tm0_ctrl, tm1_ctrl, tm2_ctrl, tm3_ctrl;
  logic [15:0] tm0_cnt, tm1_cnt, tm2_cnt, tm3_cnt;
  logic [3:0]  tick, reload, ovf, irq;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_matched = 0;
  logic drain_req = 1'b0;
  logic [3:0] mon_obs;
  sb_t  sb_q [$];

  timer_sched dut (
    .clock_16 (clk),
    .reset    (rst),
    .tm0_ctrl (tm0_ctrl),
    .tm1_ctrl (tm1_ctrl),
    .tm2_ctrl (tm2_ctrl),
    .tm3_ctrl (tm3_ctrl),
    .tm0_cnt  (tm0_cnt),
    .tm1_cnt  (tm1_cnt),
    .tm2_cnt  (tm2_cnt),
    .tm3_cnt  (tm3_cnt),
    .tick     (tick),
    .reload   (reload),
    .ovf      (ovf),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input tag_t tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input tag_t tag, input int sel,
                           input logic [3:0] mask, input logic [3:0] val);
    sb_t e;
    e.cyc = c; e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [15:0] v);
    tm0_ctrl = v; tm1_ctrl = v; tm2_ctrl = v; tm3_ctrl = v;
  endtask

  task automatic set_cnt(input logic [15:0] v);
    tm0_cnt = v; tm1_cnt = v; tm2_cnt = v; tm3_cnt = v;
  endtask

  // Sole checker: compares every entry due this cycle, then reports unmatched leftovers.
  always @(negedge clk) begin
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc == cyc) begin
        case (sb_q[i].sel)
          SelTick: mon_obs = tick;
          SelRld:  mon_obs = reload;
          SelOvf:  mon_obs = ovf;
          default: mon_obs = irq;
        endcase
        check_val(sb_q[i].tag, 32'(mon_obs & sb_q[i].mask), 32'(sb_q[i].val & sb_q[i].mask));
        n_matched++;
      end
    end
    if (drain_req) begin
      check_val("sb_drain", 32'(n_matched), 32'(sb_q.size()));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst = 1'b1;
    set_ctrl(16'h0000);
    set_cnt(16'h0000);
    step(3);
    b = cyc;
    expect_at(b, "rst_tick", SelTick, 4'hF, 4'h0);
    expect_at(b, "rst_reload", SelRld, 4'hF, 4'h0);
    expect_at(b, "rst_ovf", SelOvf, 4'hF, 4'h0);
    expect_at(b, "rst_irq", SelIrq, 4'hF, 4'h0);
    rst = 1'b0;
    step(2);

    // Timer 0, divide-by-1, IRQ disabled
    b = cyc;
    tm0_ctrl = 16'h0080;
    expect_at(b, "t0_idle_tick", SelTick, 4'h1, 4'h0);
    expect_at(b, "t0_idle_rld", SelRld, 4'h1, 4'h0);
    expect_at(b + 1, "t0_start_rld", SelRld, 4'h1, 4'h1);
    expect_at(b + 1, "t0_start_tick", SelTick, 4'h1, 4'h0);
    for (int k = 2; k <= 4; k++) begin
      expect_at(b + k, "t0_run_tick", SelTick, 4'h1, 4'h1);
      expect_at(b + k, "t0_run_ovf", SelOvf, 4'h1, 4'h0);
      expect_at(b + k, "t0_run_rld", SelRld, 4'h1, 4'h0);
    end
    expect_at(b + 5, "t0_ovf_tick", SelTick, 4'h1, 4'h1);
    expect_at(b + 5, "t0_ovf", SelOvf, 4'h1, 4'h1);
    expect_at(b + 5, "t0_ovf_rld", SelRld, 4'h1, 4'h1);
    expect_at(b + 6, "t0_irq_off", SelIrq, 4'h1, 4'h0);
    expect_at(b + 6, "t0_ovf_clr", SelOvf, 4'h1, 4'h0);
    step(5);
    tm0_cnt = 16'hFFFF;
    step(1);
    tm0_cnt = 16'h0000;
    step(1);
    tm0_ctrl = 16'h0000;
    expect_at(b + 7, "t0_stop_last", SelTick, 4'h1, 4'h1);
    expect_at(b + 8, "t0_stopped", SelTick, 4'h1, 4'h0);
    expect_at(b + 9, "t0_stopped2", SelTick, 4'h1, 4'h0);
    expect_at(b + 10, "t0_restart_rld0", SelRld, 4'h1, 4'h0);
    step(3);
    tm0_ctrl = 16'h0080;
    expect_at(b + 11, "t0_restart_rld", SelRld, 4'h1, 4'h1);
    expect_at(b + 11, "t0_restart_tk0", SelTick, 4'h1, 4'h0);
    expect_at(b + 12, "t0_restart_tk1", SelTick, 4'h1, 4'h1);
    expect_at(b + 12, "t0_restart_rldx", SelRld, 4'h1, 4'h0);
    step(3);
    tm0_ctrl = 16'h0000;
    step(2);

    // Timer 1, divide-by-64 with IRQ, then prescale switched mid-count
    b = cyc;
    tm1_ctrl = 16'h00C1;
    expect_at(b + 1, "t1_rld", SelRld, 4'h2, 4'h2);
    expect_at(b + 2, "t1_run_notick", SelTick, 4'h2, 4'h0);
    expect_at(b + 64, "t1_pre_tick", SelTick, 4'h2, 4'h0);
    expect_at(b + 65, "t1_tick1", SelTick, 4'h2, 4'h2);
    expect_at(b + 66, "t1_post_tick", SelTick, 4'h2, 4'h0);
    expect_at(b + 127, "t1_max_noovf", SelOvf, 4'h2, 4'h0);
    expect_at(b + 128, "t1_pre_tick2", SelTick, 4'h2, 4'h0);
    expect_at(b + 128, "t1_max_noovf2", SelOvf, 4'h2, 4'h0);
    expect_at(b + 129, "t1_tick2", SelTick, 4'h2, 4'h2);
    expect_at(b + 129, "t1_ovf", SelOvf, 4'h2, 4'h2);
    expect_at(b + 129, "t1_ovf_rld", SelRld, 4'h2, 4'h2);
    expect_at(b + 130, "t1_irq", SelIrq, 4'h2, 4'h2);
    expect_at(b + 130, "t1_rld_clr", SelRld, 4'h2, 4'h0);
    expect_at(b + 131, "t1_irq_1cyc", SelIrq, 4'h2, 4'h0);
    expect_at(b + 629, "t1_psc3_quiet", SelTick, 4'h2, 4'h0);
    expect_at(b + 630, "t1_psc_switch", SelTick, 4'h2, 4'h2);
    expect_at(b + 631, "t1_psc_wrap", SelTick, 4'h2, 4'h0);
    expect_at(b + 693, "t1_psc1_pre", SelTick, 4'h2, 4'h0);
    expect_at(b + 694, "t1_psc1_tick", SelTick, 4'h2, 4'h2);
    step(127);
    tm1_cnt = 16'hFFFF;
    step(3);
    tm1_cnt = 16'h0000;
    tm1_ctrl = 16'h00C3;
    step(500);
    tm1_ctrl = 16'h00C1;
    step(65);
    tm1_ctrl = 16'h0000;
    step(2);

    // Cascade 0->1->2, with timer 0 stopped in its overflow cycle
    b = cyc;
    tm0_ctrl = 16'h00C0;
    tm1_ctrl = 16'h0084;
    tm2_ctrl = 16'h0084;
    expect_at(b + 1, "cas_rld", SelRld, 4'h7, 4'h7);
    expect_at(b + 1, "cas_start_tk", SelTick, 4'h7, 4'h0);
    expect_at(b + 2, "cas_run_tk", SelTick, 4'h7, 4'h1);
    expect_at(b + 2, "cas_run_ovf", SelOvf, 4'h7, 4'h0);
    expect_at(b + 3, "cas_run_tk2", SelTick, 4'h7, 4'h1);
    expect_at(b + 4, "cas_ripple_tk", SelTick, 4'h7, 4'h7);
    expect_at(b + 4, "cas_ripple_ovf", SelOvf, 4'h7, 4'h3);
    expect_at(b + 4, "cas_ripple_rld", SelRld, 4'h7, 4'h3);
    expect_at(b + 5, "cas_irq", SelIrq, 4'h7, 4'h1);
    expect_at(b + 5, "cas_idle_tk", SelTick, 4'h7, 4'h0);
    expect_at(b + 5, "cas_idle_ovf", SelOvf, 4'h7, 4'h0);
    expect_at(b + 5, "cas_idle_rld", SelRld, 4'h7, 4'h0);
    expect_at(b + 6, "cas_pred_idle", SelTick, 4'h7, 4'h0);
    expect_at(b + 6, "cas_irq_1cyc", SelIrq, 4'h7, 4'h0);
    step(4);
    tm0_cnt = 16'hFFFF;
    tm1_cnt = 16'hFFFF;
    tm0_ctrl = 16'h0040;
    step(3);
    set_ctrl(16'h0000);
    set_cnt(16'h0000);
    step(2);

    // Reset while all four run with IRQ pending, start held through release
    b = cyc;
    set_ctrl(16'h00C0);
    expect_at(b + 1, "rr_rld", SelRld, 4'hF, 4'hF);
    expect_at(b + 2, "rr_tick", SelTick, 4'hF, 4'hF);
    expect_at(b + 3, "rr_ovf", SelOvf, 4'hF, 4'hF);
    expect_at(b + 3, "rr_ovf_rld", SelRld, 4'hF, 4'hF);
    expect_at(b + 4, "rr_irq", SelIrq, 4'hF, 4'h0);
    expect_at(b + 4, "rr_tick0", SelTick, 4'hF, 4'h0);
    expect_at(b + 4, "rr_rld0", SelRld, 4'hF, 4'h0);
    expect_at(b + 4, "rr_ovf0", SelOvf, 4'hF, 4'h0);
    expect_at(b + 6, "rr_rel_rld0", SelRld, 4'hF, 4'h0);
    expect_at(b + 7, "rr_rel_rld", SelRld, 4'hF, 4'hF);
    expect_at(b + 7, "rr_rel_tick0", SelTick, 4'hF, 4'h0);
    expect_at(b + 8, "rr_rel_tick", SelTick, 4'hF, 4'hF);
    expect_at(b + 8, "rr_rel_rldx", SelRld, 4'hF, 4'h0);
    step(3);
    set_cnt(16'hFFFF);
    rst = 1'b1;
    step(2);
    set_cnt(16'h0000);
    step(1);
    rst = 1'b0;
    step(4);

    drain_req = 1'b1;
    step(4);
    $display("FAIL drain: got no summary expected summary");
    $fatal(1, "drain did not complete");
  end

endmodule
